// File: rtl/card_shoe_pkg.sv
// card_shoe_pkg: shared types, constants and helpers for the card shoe.
//   state_t    : FSM state encoding (IDLE, PROBE)
//   RANKS      : ranks per suit (13)
//   SUITS      : suits per deck (4)
//   LFSR_TAPS  : feedback mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   fold_rank  : maps a 4-bit random value onto a rank index 0..12
package card_shoe_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } state_t;

  localparam int unsigned RANKS     = 13;
  localparam int unsigned SUITS     = 4;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] fold_rank(input logic [3:0] v);
    return (v < 4'(RANKS)) ? v : v - 4'(RANKS);
  endfunction

endpackage

// File: rtl/card_shoe_if.sv
// card_shoe_if: request/response bundle between the dealing datapath and
// the card shoe.
//   deal_req   : request one card (datapath -> shoe)
//   shuffle    : reload the full shoe (datapath -> shoe)
//   new_card   : dealt rank 1..13, holds last value (shoe -> datapath)
//   card_valid : one-cycle pulse, new_card updated in the same cycle
//   busy       : shoe is probing the rank table
//   empty      : no cards left in the shoe
//   cards_left : cards remaining
// Modports: master = datapath side, slave = shoe side.
interface card_shoe_if;

  logic       deal_req;
  logic       shuffle;
  logic [3:0] new_card;
  logic       card_valid;
  logic       busy;
  logic       empty;
  logic [7:0] cards_left;

  modport master (
    output deal_req, shuffle,
    input  new_card, card_valid, busy, empty, cards_left
  );

  modport slave (
    input  deal_req, shuffle,
    output new_card, card_valid, busy, empty, cards_left
  );

endinterface

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, shifts every cycle.
//   fast_clock : clock, rising edge
//   resetb     : asynchronous active-low reset, loads seed
//   seed       : reset value; zero is replaced by 16'h0001 (lock-up state)
//   q          : current register contents
module lfsr16
  import card_shoe_pkg::*;
(
  input  logic        fast_clock,
  input  logic        resetb,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;
  logic [15:0] seed_eff;

  assign seed_eff = (seed == '0) ? 16'h0001 : seed;
  assign q_d      = {q_q[14:0], ^(q_q & LFSR_TAPS)};
  assign q        = q_q;

  always_ff @(posedge fast_clock or negedge resetb) begin
    if (!resetb) q_q <= seed_eff;
    else         q_q <= q_d;
  end

endmodule

// File: rtl/card_shoe.sv
// card_shoe: deals ranks 1..13 without replacement from a shoe of DECKS*52
// cards. A random start rank is drawn from the LFSR and the per-rank count
// table is probed linearly until a non-empty rank is found.
//   fast_clock : clock, rising edge
//   resetb     : asynchronous active-low reset
//   bus        : card_shoe_if.slave (deal_req, shuffle in; new_card,
//                card_valid, busy, empty, cards_left out)
// Parameters: DECKS (1..4), LFSR_SEED (0 is replaced by 16'h0001).
// Optional feature macro CARD_SHOE_AUTOSHUFFLE_EN: a request on an empty
// shoe reloads it and deals; when undefined such a request is ignored.
module card_shoe
  import card_shoe_pkg::*;
#(
  parameter int unsigned DECKS     = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        fast_clock,
  input  logic        resetb,
  card_shoe_if.slave  bus
);

  localparam int unsigned CW         = $clog2(SUITS * DECKS + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(SUITS * DECKS);
  localparam logic [7:0] FULL_SHOE   = 8'(RANKS * SUITS * DECKS);

  logic [15:0]   lfsr_q;
  logic [11:0]   lfsr_unused;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] count_q [RANKS];
  logic [CW-1:0] count_d [RANKS];
  logic [7:0]    cards_left_q, cards_left_d;
  logic [3:0]    new_card_q, new_card_d;
  logic          card_valid_q, card_valid_d;
  logic          busy_q, busy_d;
  logic          empty_q, empty_d;

  lfsr16 u_lfsr (
    .fast_clock (fast_clock),
    .resetb     (resetb),
    .seed       (LFSR_SEED),
    .q          (lfsr_q)
  );

  assign lfsr_unused = lfsr_q[15:4];

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    count_d      = count_q;
    cards_left_d = cards_left_q;
    new_card_d   = new_card_q;
    card_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.shuffle) begin
          for (int unsigned i = 0; i < RANKS; i++) count_d[i] = FULL_CNT;
          cards_left_d = FULL_SHOE;
        end else if (bus.deal_req) begin
          if (cards_left_q != '0) begin
            cand_d  = fold_rank(lfsr_q[3:0]);
            state_d = PROBE;
          end
`ifdef CARD_SHOE_AUTOSHUFFLE_EN
          else begin
            // Reload and draw at the same edge so latency matches a normal deal.
            for (int unsigned i = 0; i < RANKS; i++) count_d[i] = FULL_CNT;
            cards_left_d = FULL_SHOE;
            cand_d       = fold_rank(lfsr_q[3:0]);
            state_d      = PROBE;
          end
`endif
        end
      end
      PROBE: begin
        if (bus.shuffle) begin
          for (int unsigned i = 0; i < RANKS; i++) count_d[i] = FULL_CNT;
          cards_left_d = FULL_SHOE;
          state_d      = IDLE;
        end else if (count_q[cand_q] != '0) begin
          new_card_d      = cand_q + 4'd1;
          count_d[cand_q] = count_q[cand_q] - CW'(1);
          cards_left_d    = cards_left_q - 8'd1;
          card_valid_d    = 1'b1;
          state_d         = IDLE;
        end else begin
          // Rank exhausted: step to the next rank, wrapping K back to A.
          cand_d = (cand_q == 4'(RANKS - 1)) ? '0 : cand_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == PROBE);
    empty_d = (cards_left_d == '0);
  end

  always_ff @(posedge fast_clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      for (int unsigned i = 0; i < RANKS; i++) count_q[i] <= FULL_CNT;
      cards_left_q <= FULL_SHOE;
      new_card_q   <= '0;
      card_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      empty_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      count_q      <= count_d;
      cards_left_q <= cards_left_d;
      new_card_q   <= new_card_d;
      card_valid_q <= card_valid_d;
      busy_q       <= busy_d;
      empty_q      <= empty_d;
    end
  end

  assign bus.new_card   = new_card_q;
  assign bus.card_valid = card_valid_q;
  assign bus.busy       = busy_q;
  assign bus.empty      = empty_q;
  assign bus.cards_left = cards_left_q;

endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: directed self-checking bench for card_shoe with DECKS = 1.
// Behaviour on an empty shoe follows CARD_SHOE_AUTOSHUFFLE_EN.
module tb_card_shoe;

  logic fast_clock = 1'b0;
  logic resetb;

  card_shoe_if bus ();

  card_shoe #(
    .DECKS     (1),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .fast_clock (fast_clock),
    .resetb     (resetb),
    .bus        (bus)
  );

  always #5 fast_clock = ~fast_clock;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge fast_clock);
    #1;
  endtask

  // One-cycle request; lat = edges from E0 to card_valid (0 = none in 20).
  task automatic deal(output int lat, output int card, output int busy_e0,
                      output int busy_v);
    bus.deal_req = 1'b1;
    tick();
    bus.deal_req = 1'b0;
    busy_e0 = int'(bus.busy);
    lat     = 0;
    card    = -1;
    busy_v  = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.card_valid) begin
        lat    = n;
        card   = int'(bus.new_card);
        busy_v = int'(bus.busy);
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, card, b0, bv, pulses;
    int tally [13];
    int bad_rank, bad_busy;

    bus.deal_req = 1'b0;
    bus.shuffle  = 1'b0;
    resetb       = 1'b0;
    repeat (3) tick();

    // 1. reset state
    check("rst_cards_left", int'(bus.cards_left), 52);
    check("rst_empty",      int'(bus.empty),      0);
    check("rst_busy",       int'(bus.busy),       0);
    check("rst_card_valid", int'(bus.card_valid), 0);
    check("rst_new_card",   int'(bus.new_card),   0);
    resetb = 1'b1;
    tick();

    // 2. deal the whole shoe
    foreach (tally[r]) tally[r] = 0;
    bad_rank = 0;
    bad_busy = 0;
    for (int i = 0; i < 52; i++) begin
      deal(lat, card, b0, bv);
      check($sformatf("deal%0d_latency_ok", i), int'(lat >= 1 && lat <= 13), 1);
      if (card >= 1 && card <= 13) tally[card-1]++;
      else bad_rank++;
      if (b0 != 1 || bv != 0) bad_busy++;
      check($sformatf("deal%0d_cards_left", i), int'(bus.cards_left), 51 - i);
    end
    foreach (tally[r]) check($sformatf("rank%0d_count", r + 1), tally[r], 4);
    check("out_of_range_ranks", bad_rank, 0);
    check("busy_profile_errors", bad_busy, 0);
    check("drained_cards_left", int'(bus.cards_left), 0);
    check("drained_empty", int'(bus.empty), 1);

    // 3. request on an empty shoe
`ifdef CARD_SHOE_AUTOSHUFFLE_EN
    deal(lat, card, b0, bv);
    check("auto_latency_ok", int'(lat >= 1 && lat <= 13), 1);
    check("auto_cards_left", int'(bus.cards_left), 51);
    check("auto_empty", int'(bus.empty), 0);
`else
    bus.deal_req = 1'b1;
    tick();
    bus.deal_req = 1'b0;
    pulses = 0;
    repeat (20) begin
      tick();
      if (bus.card_valid) pulses++;
    end
    check("empty_req_pulses", pulses, 0);
    check("empty_req_empty", int'(bus.empty), 1);
    check("empty_req_busy", int'(bus.busy), 0);
`endif

    // 4. shuffle, 10 deals, then shuffle + request together
    bus.shuffle = 1'b1;
    tick();
    bus.shuffle = 1'b0;
    check("shuffle_cards_left", int'(bus.cards_left), 52);
    check("shuffle_empty", int'(bus.empty), 0);
    for (int i = 0; i < 10; i++) begin
      deal(lat, card, b0, bv);
      check($sformatf("pre_shuf_deal%0d_ok", i), int'(lat >= 1 && lat <= 13), 1);
    end
    check("ten_deals_cards_left", int'(bus.cards_left), 42);
    bus.shuffle  = 1'b1;
    bus.deal_req = 1'b1;
    tick();
    bus.shuffle  = 1'b0;
    bus.deal_req = 1'b0;
    check("shuf_req_cards_left", int'(bus.cards_left), 52);
    check("shuf_req_busy", int'(bus.busy), 0);
    pulses = 0;
    repeat (15) begin
      tick();
      if (bus.card_valid) pulses++;
    end
    check("shuf_req_pulses", pulses, 0);

    // 5. asynchronous reset while probing
    for (int i = 0; i < 2; i++) deal(lat, card, b0, bv);
    check("pre_reset_cards_left", int'(bus.cards_left), 50);
    bus.deal_req = 1'b1;
    tick();
    bus.deal_req = 1'b0;
    check("pre_reset_busy", int'(bus.busy), 1);
    #2 resetb = 1'b0;
    #1;
    check("async_rst_card_valid", int'(bus.card_valid), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_cards_left", int'(bus.cards_left), 52);
    #2 resetb = 1'b1;
    pulses = 0;
    repeat (15) begin
      tick();
      if (bus.card_valid) pulses++;
    end
    check("post_rst_pulses", pulses, 0);

    // 6. deal_req held high for 200 cycles
    begin
      int b2b, dec_err, overlap, rises, prev_left;
      logic prev_valid, prev_busy;
      b2b = 0; dec_err = 0; overlap = 0; rises = 0; pulses = 0;
      prev_valid = bus.card_valid;
      prev_busy  = bus.busy;
      prev_left  = int'(bus.cards_left);
      bus.deal_req = 1'b1;
      repeat (200) begin
        tick();
        if (bus.card_valid) begin
          pulses++;
          if (prev_valid) b2b++;
          if (bus.busy) overlap++;
          if (int'(bus.cards_left) != ((prev_left == 0) ? 51 : prev_left - 1))
            dec_err++;
        end else if (int'(bus.cards_left) != prev_left) begin
          dec_err++;
        end
        if (bus.busy && !prev_busy) rises++;
        prev_valid = bus.card_valid;
        prev_busy  = bus.busy;
        prev_left  = int'(bus.cards_left);
      end
      bus.deal_req = 1'b0;
      check("held_back_to_back", b2b, 0);
      check("held_decrement_errors", dec_err, 0);
      check("held_valid_while_busy", overlap, 0);
      check("held_min_pulses", int'(pulses >= 14), 1);
      check("held_accepts_vs_pulses", rises - int'(bus.busy), pulses);
`ifndef CARD_SHOE_AUTOSHUFFLE_EN
      check("held_conservation", pulses + int'(bus.cards_left), 52);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/card_shoe.md
# card_shoe

Card source for the baccarat datapath. Deals card ranks 1..13 from a finite shoe of DECKS×52 cards without replacement, using a free-running LFSR for randomness and a per-rank remaining-count table. It sits directly upstream of the dealing datapath: the datapath issues a one-cycle request on each slow-clock advance and loads `new_card` when `card_valid` pulses.

## Interface

Parameters:
- DECKS, 1, number of 52-card decks in the shoe; legal range 1..4.
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- fast_clock  in  1  single clock for the whole block, rising-edge; all state changes on this edge.
- resetb  in  1  asynchronous, active-low reset.
- deal_req  in  1  request one card; sampled only in IDLE.
- shuffle  in  1  reload the full shoe.
- new_card  out  4  dealt rank, 1..13 (1 = A, 11..13 = J/Q/K); holds the last dealt value.
- card_valid  out  1  one-cycle pulse; `new_card` is updated in the same cycle.
- busy  out  1  high while in PROBE.
- empty  out  1  high when `cards_left == 0`.
- cards_left  out  8  cards remaining in the shoe.

## Operation

- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts every cycle regardless of state.
- Rank table: 13 counters, each of width clog2(4·DECKS+1), reset to 4·DECKS.
- Fold function: fold(v) = v if v < 13, else v − 13. Applied to lfsr[3:0].
- States:
  - IDLE
    - shuffle = 1: reload the table and set `cards_left` to 52·DECKS; stay in IDLE. This takes priority over `deal_req`, so a simultaneous request is dropped.
    - deal_req = 1 and cards_left > 0: cand ← fold(lfsr[3:0]); go to PROBE.
    - deal_req = 1 and cards_left = 0: see Configuration.
  - PROBE
    - shuffle = 1: abort the draw (no `card_valid`), reload the shoe, go to IDLE.
    - count[cand] ≠ 0: new_card ← cand+1, decrement count[cand] and `cards_left`, card_valid ← 1, go to IDLE.
    - count[cand] = 0: cand ← (cand = 12) ? 0 : cand+1; stay in PROBE.
- Linear probing always terminates within 13 probes, because `cards_left` > 0 on entry.
- `deal_req` is level-sampled. Holding it high issues back-to-back draws, one per IDLE visit. A request seen outside IDLE is ignored, not queued.
- Reset values:
  - state IDLE; new_card 0; card_valid 0; busy 0; empty 0.
  - cards_left 52·DECKS; all counts 4·DECKS; lfsr LFSR_SEED.
- Reset mid-PROBE: the draw is abandoned immediately and all of the above values are restored asynchronously.

## Timing

- E0 is the edge that samples `deal_req` in IDLE. k ∈ [0,12] is the number of empty ranks skipped during probing.
- `card_valid` rises at edge E(k+1) and clears at edge E(k+2).
- Worst-case latency from E0 to `card_valid` is 13 edges.
- `busy` is high from E0 to E(k+1), is registered, and is low in the `card_valid` cycle.
- `cards_left`, `empty`, and `new_card` update at the same edge as `card_valid` rises.
- A new request can be sampled at E(k+2), so the minimum period between deals is k+2 cycles.
- The shuffle reload is visible one edge after `shuffle` is sampled.

## Configuration

- CARD_SHOE_AUTOSHUFFLE_EN defined:
  - A request in IDLE with cards_left = 0 reloads the shoe and loads cand at the same edge E0, then enters PROBE.
  - The card is always delivered, with latency identical to normal dealing.
- Undefined:
  - That request is ignored and no `card_valid` is produced.
  - `empty` stays high until `shuffle` or reset.

## Structure

- Package `card_shoe_pkg` holds:
  - state enum {IDLE, PROBE}
  - constants RANKS = 13, SUITS = 4, LFSR_TAPS
  - function `fold_rank`
- One sub-module, `lfsr16`, with ports fast_clock, resetb, seed, and q[15:0], free-running.
- The rank table and FSM live in `card_shoe`.

## Test plan

1. Reset with DECKS = 1 → cards_left = 52, empty = 0, busy = 0, card_valid = 0, new_card = 0.
2. 52 single-cycle requests, each issued after the previous `card_valid` → 52 pulses. Every `new_card` is in 1..13, each rank appears exactly 4 times, the final cards_left = 0, and empty = 1. Every latency is ≤ 13 edges.
3. 53rd request:
   - without the macro → no `card_valid` within 20 cycles and empty stays 1;
   - with CARD_SHOE_AUTOSHUFFLE_EN → `card_valid` within 13 edges, cards_left = 51, empty = 0.
4. `shuffle` and `deal_req` high in the same IDLE cycle after 10 deals → no `card_valid`, and cards_left = 52 on the next cycle.
5. resetb pulsed low while busy = 1 → card_valid = 0, busy = 0, cards_left = 52 without waiting for a clock edge. No pulse follows.
6. deal_req held high for 200 cycles from a full shoe → each `card_valid` pulse is followed by at least 1 low cycle. `cards_left` decrements by exactly 1 per pulse, and no request is accepted while busy = 1.
